// File: rtl/tlcd_arbiter_if.sv
// Bundle between the display clients and the LCD arbiter: level requests with
// packed text frames in, grant/status and the controller drive signals out.
interface tlcd_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]     REQ;
    logic [NUM_REQ*128-1:0] REQ_UPPER;
    logic [NUM_REQ*128-1:0] REQ_LOWER;
    logic [NUM_REQ-1:0]     GNT;
    logic                   BUSY;
    logic [OWN_W-1:0]       CUR_OWNER;
    logic                   LCD_ENABLE;
    logic [127:0]           LCD_UPPER;
    logic [127:0]           LCD_LOWER;

    // Client side: raises requests and supplies text, observes the arbiter.
    modport master (
        output REQ, REQ_UPPER, REQ_LOWER,
        input  GNT, BUSY, CUR_OWNER, LCD_ENABLE, LCD_UPPER, LCD_LOWER
    );

    // Arbiter side.
    modport slave (
        input  REQ, REQ_UPPER, REQ_LOWER,
        output GNT, BUSY, CUR_OWNER, LCD_ENABLE, LCD_UPPER, LCD_LOWER
    );
endinterface

// File: rtl/tlcd_arbiter.sv
// Round-robin arbiter sharing one text-LCD controller among several clients.
// A grant latches the winner's two text lines, pulses LCD_ENABLE after one
// setup cycle, then blocks new grants for a fixed busy window because the
// controller gives no completion indication.
module tlcd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ENABLE_HIGH = 2,
    parameter int BUSY_CYCLES = 4000
) (
    input  logic          CLK,
    input  logic          RESETN,
    tlcd_arbiter_if.slave bus
);
    localparam int OWN_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_nxt;
    logic [15:0]        cnt_q, cnt_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
    logic               busy_q, busy_nxt;
    logic [OWN_W-1:0]   owner_q, owner_nxt;
    logic               en_q, en_nxt;
    logic [127:0]       upper_q, upper_nxt;
    logic [127:0]       lower_q, lower_nxt;

    logic               win_found;
    logic [OWN_W-1:0]   win_idx;
    logic [15:0]        cnt_inc;

    assign cnt_inc = cnt_q + 16'd1;

    // Round-robin search: first set request strictly after the last owner, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(owner_q) + off) % NUM_REQ;
            if (!win_found && bus.REQ[idx]) begin
                win_found = 1'b1;
                win_idx   = OWN_W'(idx);
            end
        end
    end

    // Next-state and output decode; registered values hold unless a state changes them.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        gnt_nxt   = '0;
        busy_nxt  = busy_q;
        owner_nxt = owner_q;
        en_nxt    = en_q;
        upper_nxt = upper_q;
        lower_nxt = lower_q;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    upper_nxt          = bus.REQ_UPPER[int'(win_idx)*128 +: 128];
                    lower_nxt          = bus.REQ_LOWER[int'(win_idx)*128 +: 128];
                    gnt_nxt[win_idx]   = 1'b1;
                    busy_nxt           = 1'b1;
                    owner_nxt          = win_idx;
                    state_nxt          = SETUP;
                end
            end
            SETUP: begin
                // Text has now been stable for a full cycle before ENABLE rises.
                en_nxt    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = PULSE;
            end
            PULSE: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == 16'(ENABLE_HIGH)) begin
                    en_nxt    = 1'b0;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == 16'(BUSY_CYCLES)) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                en_nxt    = 1'b0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops everything at once, even mid-pulse.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= OWN_W'(NUM_REQ - 1);
            en_q    <= 1'b0;
            upper_q <= '0;
            lower_q <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            gnt_q   <= gnt_nxt;
            busy_q  <= busy_nxt;
            owner_q <= owner_nxt;
            en_q    <= en_nxt;
            upper_q <= upper_nxt;
            lower_q <= lower_nxt;
        end
    end

    assign bus.GNT        = gnt_q;
    assign bus.BUSY       = busy_q;
    assign bus.CUR_OWNER  = owner_q;
    assign bus.LCD_ENABLE = en_q;
    assign bus.LCD_UPPER  = upper_q;
    assign bus.LCD_LOWER  = lower_q;
endmodule

// File: doc/tlcd_arbiter.md
# tlcd_arbiter

Shares the single text-LCD controller among up to `NUM_REQ` display clients: game logic, status and debug screens. On each grant it latches one requester's 32-character frame and pulses the controller's start input. It then holds the text stable and blocks further starts for a fixed busy window, because the controller has no done output. It sits between the client modules and the `ENABLE`/`TEXT_STRING_UPPER`/`TEXT_STRING_LOWER` inputs of the LCD controller.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ENABLE_HIGH`, 2: cycles `LCD_ENABLE` stays high per start; at least 1.
- `BUSY_CYCLES`, 4000: cycles from `LCD_ENABLE` rise until the next start is allowed. Must exceed `ENABLE_HIGH` and be at most 65535. The default covers a full controller refresh at 1 MHz, about 3.1 k cycles.
- `CLK` in 1: system clock (1 MHz).
- `RESETN` in 1: asynchronous, active-low reset.
- `REQ` in `NUM_REQ`: level request, one bit per requester.
- `REQ_UPPER` in `NUM_REQ`*128: upper-line text; requester i occupies bits [i*128 +: 128].
- `REQ_LOWER` in `NUM_REQ`*128: lower-line text, same packing.
- `GNT` out `NUM_REQ`: one-hot, one-cycle pulse marking the accepted requester.
- `BUSY` out 1: high from grant until the busy window ends.
- `CUR_OWNER` out clog2(`NUM_REQ`): index of the last granted requester.
- `LCD_ENABLE` out 1: drives the controller `ENABLE`.
- `LCD_UPPER` out 128: drives the controller `TEXT_STRING_UPPER`.
- `LCD_LOWER` out 128: drives the controller `TEXT_STRING_LOWER`.

## Operation
- **Reset values:** `GNT`=0, `BUSY`=0, `LCD_ENABLE`=0, `LCD_UPPER`/`LCD_LOWER`=0. `CUR_OWNER`=`NUM_REQ`-1, so requester 0 wins first. State is IDLE and the 16-bit counter is 0.
- **IDLE:** if any `REQ` bit is high, pick the first set bit searching upward from `CUR_OWNER`+1, wrapping modulo `NUM_REQ`. On that edge:
  - latch the winner's `REQ_UPPER`/`REQ_LOWER` slices into `LCD_UPPER`/`LCD_LOWER`;
  - set `GNT` for the winner, `BUSY`=1, `CUR_OWNER`=winner;
  - go to SETUP.
- **SETUP (1 cycle):** `GNT` returns to 0, `LCD_ENABLE` goes to 1, counter clears, go to PULSE. The text is stable for one full cycle before `ENABLE` rises.
- **PULSE:** counter increments. When it reaches `ENABLE_HIGH`, drive `LCD_ENABLE`=0 and go to HOLD.
- **HOLD:** counter keeps incrementing. When it reaches `BUSY_CYCLES`, set `BUSY`=0 and go to IDLE.
- **Outside a grant edge:** `REQ`, `REQ_UPPER` and `REQ_LOWER` are ignored. `LCD_UPPER`/`LCD_LOWER` keep the last frame until the next grant and are never cleared except by reset.
- **Request lifetime:** requesters drop `REQ` after `GNT`. A requester still asserting `REQ` is served again, but only after every other pending requester (round robin). A `REQ` withdrawn before its grant is never served.
- **Single requester:** re-granted each window while `REQ` stays high, giving a repeated refresh.
- **Unused states:** go to IDLE with `LCD_ENABLE`=0 and `BUSY`=0.
- **Reset mid-operation:** all outputs return to their reset values immediately (asynchronously), including dropping `LCD_ENABLE` mid-pulse.

## Timing
- Let E0 be the IDLE edge that samples a request.
- After E0: `GNT` and `BUSY` high, text valid.
- After E1: `GNT` low, `LCD_ENABLE` high.
- After E(1+`ENABLE_HIGH`): `LCD_ENABLE` low.
- After E(1+`BUSY_CYCLES`): `BUSY` low, state IDLE.
- The earliest next `GNT` appears after E(2+`BUSY_CYCLES`), so the grant-to-grant period is `BUSY_CYCLES`+2 cycles.
- `LCD_ENABLE` is low for at least `BUSY_CYCLES`-`ENABLE_HIGH`+2 cycles between pulses, which guarantees a clean rising edge for the controller.
- The controller detects `ENABLE` on its rising edge only; no other handshake exists.

## Test plan
All scenarios use `NUM_REQ`=4, `ENABLE_HIGH`=2, `BUSY_CYCLES`=20.

1. **Reset state:** hold `RESETN`=0 -> all outputs 0, `CUR_OWNER`=3. Release and keep `REQ`=0 -> no activity for 100 cycles.
2. **Single request:** `REQ`=0001, `REQ_UPPER[127:0]`="HELLO..." -> `GNT`=0001 for exactly 1 cycle and `LCD_UPPER` equals that slice. `LCD_ENABLE` is high 2 cycles starting 1 cycle after `GNT`. `BUSY` is high 21 cycles.
3. **Round robin:** `REQ`=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, spaced 22 cycles apart.
4. **Stable text:** with `REQ`=0110 and `CUR_OWNER`=1 -> `GNT`=0100 first. Change `REQ_UPPER` slice 2 during HOLD -> `LCD_UPPER` unchanged until the next grant.
5. **Withdraw and ignore:** pulse `REQ[3]` for 5 cycles, only while `BUSY`=1 -> requester 3 is never granted.
6. **Reset mid-pulse:** assert `RESETN`=0 during PULSE -> `LCD_ENABLE`, `BUSY` and the text go to 0 immediately. After release, a pending `REQ`=0010 is granted from IDLE normally.
